// File: rtl/adc_sample_sequencer.sv
// Round-robin ADC sample scheduler writing each channel into its own RAM ring buffer.
// Optional macro ADC_SEQ_TAG_EN tags every written word with channel and ring index.
module adc_sample_sequencer #(
    parameter int                NUM_CH    = 2,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 12,
    parameter int                DEPTH     = 640,
    parameter int                IDX_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'h800,
    parameter int                INTERVAL  = 125000,
    parameter int                CNT_W     = 18
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_ready,
    output logic [NUM_CH*IDX_W-1:0]  head_idx,
    output logic [NUM_CH-1:0]        wrap_pulse,
    output logic [3:0]               cur_ch,
    output logic [15:0]              overrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_WRITE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               handshake;
    logic [3:0]         sel;
    logic [3:0]         sel_inc;
    logic [IDX_W-1:0]   head_r [NUM_CH];
    logic [DATA_W-1:0]  sample_sel;
    logic [IDX_W-1:0]   head_sel;
    logic [ADDR_W-1:0]  addr_calc;
    logic [DATA_W-1:0]  data_calc;

    assign tick      = enable && (tick_cnt == CNT_W'(INTERVAL - 1));
    assign wr_en     = (state == ST_WRITE);
    assign handshake = wr_en && wr_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (tick) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_WRITE;
            ST_WRITE:   if (handshake) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Channel select mux for the sample and its ring position
    always_comb begin
        sample_sel = '0;
        head_sel   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel == 4'(c)) begin
                sample_sel = ch_data[c*DATA_W +: DATA_W];
                head_sel   = head_r[c];
            end
        end
    end

    always_comb begin
        addr_calc = BASE_ADDR + ADDR_W'(int'(sel) * DEPTH) + ADDR_W'(head_sel);
`ifdef ADC_SEQ_TAG_EN
        data_calc = {sel, 12'(head_sel), sample_sel[15:0]};
`else
        data_calc = sample_sel;
`endif
        sel_inc = (int'(sel) == NUM_CH - 1) ? 4'd0 : sel + 4'd1;
    end

    // Capture stage: latch channel on tick, then address and data one cycle later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (state == ST_IDLE && tick) begin
                sel <= cur_ch;
            end
            if (state == ST_CAPTURE) begin
                wr_addr <= addr_calc;
                wr_data <= data_calc;
            end
        end
    end

    // Write completion: advance the ring head and the round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                head_r[c] <= '0;
            end
            wrap_pulse <= '0;
            cur_ch     <= '0;
        end else begin
            wrap_pulse <= '0;
            if (handshake) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (sel == 4'(c)) begin
                        if (head_r[c] == IDX_W'(DEPTH - 1)) begin
                            head_r[c]     <= '0;
                            wrap_pulse[c] <= 1'b1;
                        end else begin
                            head_r[c] <= head_r[c] + IDX_W'(1);
                        end
                    end
                end
                cur_ch <= sel_inc;
            end
        end
    end

    // A tick that finds the sequencer busy is dropped and counted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (tick && state != ST_IDLE && overrun_cnt != 16'hFFFF) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_head
        assign head_idx[g*IDX_W +: IDX_W] = head_r[g];
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer: a transaction-level model predicts every RAM write
// and the exported ring state; a monitor compares them against the DUT once per cycle.
`timescale 1ns/1ps
module tb_adc_sample_sequencer;

    localparam int NUM_CH   = 2;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 3;
    localparam int IDX_W    = 10;
    localparam int INTERVAL = 4;
    localparam int CNT_W    = 18;
    localparam logic [ADDR_W-1:0] BASE = 12'h100;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ready;
    logic [NUM_CH*IDX_W-1:0]  head_idx;
    logic [NUM_CH-1:0]        wrap_pulse;
    logic [3:0]               cur_ch;
    logic [15:0]              overrun_cnt;

    adc_sample_sequencer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W),
        .BASE_ADDR(BASE), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .head_idx(head_idx), .wrap_pulse(wrap_pulse), .cur_ch(cur_ch), .overrun_cnt(overrun_cnt)
    );

    initial forever #5 clock = ~clock;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               sb[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0] log_data[$];
    int                wrap_seen[NUM_CH];
    int                n_checks = 0;
    int                n_pass = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: a tick starts a write if none is outstanding, the sample is taken on
    // the following cycle, and the write retires on the first ready cycle after that.
    int                m_run = 0;
    bit                m_pend = 0;
    int                m_age = 0;
    int                m_sel = 0;
    int                m_next = 0;
    int                m_head[NUM_CH];
    int                m_ovr = 0;
    logic [NUM_CH-1:0] m_wrap = '0;
    bit                m_tick;
    bit                m_busy;
    wr_t               m_e;
    logic [DATA_W-1:0] m_sample;

    function automatic logic [NUM_CH*IDX_W-1:0] exp_head();
        logic [NUM_CH*IDX_W-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*IDX_W +: IDX_W] = IDX_W'(m_head[c]);
        return v;
    endfunction

    initial begin
        foreach (m_head[c]) m_head[c] = 0;
        foreach (wrap_seen[c]) wrap_seen[c] = 0;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_run = 0; m_pend = 0; m_age = 0; m_sel = 0; m_next = 0; m_ovr = 0; m_wrap = '0;
                foreach (m_head[c]) m_head[c] = 0;
                sb.delete();
            end else begin
                m_tick = enable && (m_run % INTERVAL == INTERVAL - 1);
                m_run  = enable ? m_run + 1 : 0;
                m_busy = m_pend;
                m_wrap = '0;
                if (m_tick && m_busy && m_ovr < 65535) m_ovr++;
                if (m_pend && m_age == 0) begin
                    m_sample = ch_data[m_sel*DATA_W +: DATA_W];
                    m_e.addr = ADDR_W'(int'(BASE) + m_sel * DEPTH + m_head[m_sel]);
`ifdef ADC_SEQ_TAG_EN
                    m_e.data = {4'(m_sel), 12'(m_head[m_sel]), m_sample[15:0]};
`else
                    m_e.data = m_sample;
`endif
                    sb.push_back(m_e);
                    m_age = 1;
                end else if (m_pend && wr_ready) begin
                    if (m_head[m_sel] == DEPTH - 1) begin
                        m_head[m_sel] = 0;
                        m_wrap[m_sel] = 1'b1;
                    end else begin
                        m_head[m_sel]++;
                    end
                    m_next = (m_sel + 1) % NUM_CH;
                    m_pend = 0;
                end
                if (m_tick && !m_busy) begin
                    m_pend = 1;
                    m_age  = 0;
                    m_sel  = m_next;
                end
            end
        end
    end

    // Monitor: compare outputs mid-cycle; pop the scoreboard on each accepted write
    initial forever begin
        @(negedge clock);
        #1;
        chk("wr_en", 64'(wr_en), 64'(m_pend && m_age == 1));
        chk("head_idx", 64'(head_idx), 64'(exp_head()));
        chk("cur_ch", 64'(cur_ch), 64'(m_next));
        chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
        chk("wrap_pulse", 64'(wrap_pulse), 64'(m_wrap));
        for (int c = 0; c < NUM_CH; c++) if (wrap_pulse[c]) wrap_seen[c]++;
        if (wr_en) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_empty: unexpected write addr 0x%0h data 0x%0h", wr_addr, wr_data);
            end else begin
                chk("wr_addr", 64'(wr_addr), 64'(sb[0].addr));
                chk("wr_data", 64'(wr_data), 64'(sb[0].data));
                if (wr_ready) begin
                    log_addr.push_back(wr_addr);
                    log_data.push_back(wr_data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0; wr_ready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (log_addr.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (log_addr.size() < n) begin
            n_checks++;
            $display("FAIL wait_writes: got %0d writes required %0d", log_addr.size(), n);
        end
    endtask

    task automatic wait_wr_en(input int budget);
        int k = 0;
        while (!wr_en && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (!wr_en) begin
            n_checks++;
            $display("FAIL wait_wr_en: wr_en 0 required 1 within %0d cycles", budget);
        end
    endtask

    logic [ADDR_W-1:0] exp_a [7] = '{12'h100, 12'h103, 12'h101, 12'h104, 12'h102, 12'h105, 12'h100};
`ifdef ADC_SEQ_TAG_EN
    logic [DATA_W-1:0] exp_d [7] = '{32'h00000AAA, 32'h10000BBB, 32'h00010AAA, 32'h10010BBB,
                                     32'h00020AAA, 32'h10020BBB, 32'h00000AAA};
`else
    logic [DATA_W-1:0] exp_d [7] = '{32'h0AAA, 32'h0BBB, 32'h0AAA, 32'h0BBB,
                                     32'h0AAA, 32'h0BBB, 32'h0AAA};
`endif

    initial begin
        int w0, w1, k, en_hi;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        reset = 1'b1; enable = 1'b0; wr_ready = 1'b1; ch_data = '0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_head_idx", 64'(head_idx), 64'(0));
        chk("rst_cur_ch", 64'(cur_ch), 64'(0));
        chk("rst_overrun", 64'(overrun_cnt), 64'(0));
        chk("rst_wrap", 64'(wrap_pulse), 64'(0));

        // Basic ordering and ring wrap
        do_reset();
        ch_data = {32'h0BBB, 32'h0AAA};
        w0 = wrap_seen[0]; w1 = wrap_seen[1];
        enable = 1'b1;
        wait_writes(5, 60);
        chk("head_ch0_after_wrap", 64'(head_idx[IDX_W-1:0]), 64'(0));
        wait_writes(7, 60);
        for (int i = 0; i < 7 && i < log_addr.size(); i++) begin
            chk($sformatf("basic_addr%0d", i), 64'(log_addr[i]), 64'(exp_a[i]));
            chk($sformatf("basic_data%0d", i), 64'(log_data[i]), 64'(exp_d[i]));
        end
        chk("wrap0_count", 64'(wrap_seen[0] - w0), 64'(1));
        chk("wrap1_count", 64'(wrap_seen[1] - w1), 64'(1));

        // Backpressure holds the write and drops ticks
        do_reset();
        ch_data = {32'h000000BB, 32'h000000AA};
        enable = 1'b1;
        wait_wr_en(20);
        wr_ready = 1'b0;
        a0 = wr_addr; d0 = wr_data;
        chk("bp_first_addr", 64'(a0), 64'(12'h100));
        repeat (9) begin
            @(negedge clock);
            chk("bp_addr_stable", 64'(wr_addr), 64'(a0));
            chk("bp_data_stable", 64'(wr_data), 64'(d0));
        end
        chk("bp_overrun", 64'(overrun_cnt), 64'(2));
        wr_ready = 1'b1;
        wait_writes(2, 40);
        if (log_addr.size() >= 2) chk("bp_next_ch1", 64'(log_addr[1]), 64'(12'h103));

        // Asynchronous reset in the middle of a stalled write
        do_reset();
        ch_data = {32'h00000022, 32'h00000011};
        enable = 1'b1;
        wait_writes(3, 40);
        wait_wr_en(20);
        wr_ready = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_overrun", 64'(overrun_cnt), 64'(1));
        chk("mid_head", 64'(head_idx), 64'({10'd1, 10'd2}));
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'(0));
        chk("mid_rst_head", 64'(head_idx), 64'(0));
        chk("mid_rst_overrun", 64'(overrun_cnt), 64'(0));
        @(negedge clock);
        reset = 1'b0; wr_ready = 1'b1;
        log_addr.delete(); log_data.delete();
        wait_writes(1, 40);
        if (log_addr.size() >= 1) chk("mid_post_addr", 64'(log_addr[0]), 64'(12'h100));

        // Enable low stops ticks; re-enable restarts the interval from zero
        do_reset();
        ch_data = {32'h00000002, 32'h00000001};
        enable = 1'b1;
        wait_writes(2, 40);
        enable = 1'b0;
        en_hi = 0;
        repeat (20) begin
            @(negedge clock);
            if (wr_en) en_hi++;
        end
        chk("dis_no_wr_en", 64'(en_hi), 64'(0));
        chk("dis_cnt_zero", 64'(dut.tick_cnt), 64'(0));
        enable = 1'b1;
        k = 0;
        while (!wr_en && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("reenable_latency", 64'(k), 64'(5));

        // Tagged word for channel 1 at ring index 2
        do_reset();
        ch_data = {32'h00001234, 32'h00000555};
        enable = 1'b1;
        wait_writes(6, 60);
`ifdef ADC_SEQ_TAG_EN
        if (log_data.size() >= 6) chk("tag_word", 64'(log_data[5]), 64'(32'h10021234));
`else
        if (log_data.size() >= 6) chk("raw_word", 64'(log_data[5]), 64'(32'h00001234));
`endif

        // Randomized run with stalls, enable toggles and occasional resets
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            ch_data  = {$urandom(), $urandom()};
            wr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
        end
        reset = 1'b0; enable = 1'b0; wr_ready = 1'b1;
        repeat (10) @(negedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Parametrised multi-channel ADC sample scheduler and ring-buffer writer.
- Generates a periodic sample tick and serves NUM_CH channels round-robin, one channel per tick.
- Writes each sample into a per-channel circular region of data RAM through a write port with a ready handshake.
- Exports per-channel head indices, wrap pulses and an overrun counter so the CPU and VGA readers can locate the newest sample.

Parameters:
- NUM_CH, 2: number of ADC channels (1..16).
- DATA_W, 32: sample and RAM word width.
- ADDR_W, 12: RAM word-address width.
- DEPTH, 640: entries per channel ring (>=2).
- IDX_W, 10: ring index width; must satisfy 2^IDX_W >= DEPTH.
- BASE_ADDR, 12'h800: address of channel 0 entry 0. Channel c's region starts at BASE_ADDR + c*DEPTH. NUM_CH*DEPTH must fit in the address space.
- INTERVAL, 125000: clock cycles between ticks (>=4).
- CNT_W, 18: tick counter width; must satisfy 2^CNT_W >= INTERVAL.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run control; low holds the tick counter at 0.
- ch_data  in  NUM_CH*DATA_W  flattened live ADC values; channel c occupies [c*DATA_W +: DATA_W].
- wr_en  out  1  RAM write request.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- wr_ready  in  1  RAM accepts the write this cycle.
- head_idx  out  NUM_CH*IDX_W  per channel: index of the next entry to be written.
- wrap_pulse  out  NUM_CH  one-cycle pulse when that channel's index wraps DEPTH-1 -> 0.
- cur_ch  out  4  channel served by the next tick.
- overrun_cnt  out  16  ticks dropped because a write was still pending.

Behaviour:
- Reset: every output and internal register is 0 (wr_en=0, head_idx=0, wrap_pulse=0, cur_ch=0, overrun_cnt=0, FSM=IDLE, counter=0).
- Tick counter:
  - enable=1: counts 0..INTERVAL-1, then returns to 0. tick=1 for exactly the cycle the counter equals INTERVAL-1.
  - enable=0: counter is forced to 0 and no ticks occur. An in-flight write still completes.
- FSM states: IDLE, CAPTURE, WRITE.
  - IDLE: on tick, latch sel=cur_ch and go to CAPTURE.
  - CAPTURE (1 cycle):
    - wr_data <= ch_data slice for sel.
    - wr_addr <= BASE_ADDR + sel*DEPTH + head_idx[sel], computed in ADDR_W-bit arithmetic.
    - Go to WRITE.
  - WRITE:
    - wr_en=1; wr_addr and wr_data are held stable.
    - On wr_en&&wr_ready (handshake):
      - head_idx[sel] increments; if it was DEPTH-1 it becomes 0 and wrap_pulse[sel] pulses on the next cycle.
      - cur_ch advances to (sel+1) mod NUM_CH.
      - Return to IDLE; wr_en falls on the next cycle.
    - wr_ready low: remain in WRITE indefinitely.
- Latency: tick in cycle T -> wr_en high in T+2. With wr_ready=1 the write completes in T+2 and head_idx updates in T+3.
- Overrun:
  - A tick arriving while the FSM is not IDLE is dropped.
  - overrun_cnt increments and saturates at 16'hFFFF.
  - cur_ch does not advance for a dropped tick.
- A tick coinciding with a handshake is an overrun; the FSM is not IDLE that cycle.
- Ring capacity is exactly DEPTH entries per channel. Writes never touch another channel's region.
- Asynchronous reset mid-WRITE: the write is abandoned, wr_en drops immediately, and all state clears.
- wrap_pulse bits are mutually exclusive; at most one is set per cycle.

Optional Feature:
- Macro: ADC_SEQ_TAG_EN.
- Defined (requires DATA_W=32, IDX_W<=12): each written word is tagged.
  - wr_data[31:28] = sel.
  - wr_data[27:16] = head_idx[sel] zero-extended to 12 bits.
  - wr_data[15:0] = sample[15:0].
- Undefined: wr_data is the raw DATA_W-bit sample.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=2, DEPTH=3, INTERVAL=4, BASE_ADDR=12'h100, wr_ready=1.
- Basic order: ch0=0x0AAA, ch1=0x0BBB, enable=1 -> writes (0x100,0x0AAA), (0x103,0x0BBB), (0x101,0x0AAA), (0x104,0x0BBB), ... with wr_en exactly 2 cycles after each tick.
- Wrap: run 6 ticks -> third ch0 write goes to 0x102, then head_idx[ch0]=0; wrap_pulse[0] pulses once; the 7th tick writes 0x100.
- Backpressure/overrun: hold wr_ready=0 for 10 cycles after the first wr_en -> wr_addr/wr_data stable; overrun_cnt=2; after wr_ready=1 the next write is channel 1.
- Reset mid-write: assert reset while wr_en=1 -> wr_en=0 immediately; head_idx=0; overrun_cnt=0; the first post-reset write goes to 0x100.
- enable low: deassert enable for 20 cycles -> no wr_en; counter reads 0; on re-enable the first tick occurs 4 cycles later.
- ADC_SEQ_TAG_EN: ch1=0x1234 at index 2 -> wr_data=0x10021234.
